mux_rr_arbiter: RTL and testbench

- Shares one N-to-1 data mux among `NREQ` valid/ready requesters.
- Picks one requester per cycle using a round-robin pointer.
- Drives the mux select and captures the selected word into a one-entry output buffer with a valid/ready handshake.
- Sits in front of the team's mux tree: it is the sequencer that owns the select lines, so no requester drives a select directly.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 47 ++++
 rtl/mux_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin mux arbiter: select-width computation and one-hot decode.
// Select-width and one-hot helpers are identical in both builds (see MUX_ARB_FIXED_PRIO_EN in mux_rr_arbiter).
package arb_pkg;

    localparam int MAX_NREQ = 32;

    function automatic int calc_sw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [4:0] idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: rotate requests by ptr, priority-encode lowest index, un-rotate.
// With MUX_ARB_FIXED_PRIO_EN defined it is a plain lowest-index priority encoder.
module rr_pick #(
    parameter int NREQ = 8,
    parameter int SW   = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [SW-1:0]   sel,
    output logic            any
);

    logic [NREQ-1:0] rot;
    logic [SW-1:0]   idx;

`ifdef MUX_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign rot        = req;
`else
    // NREQ is a power of two, so SW-bit addition wraps modulo NREQ.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[SW'(i) + ptr];
        end
    end
`endif

    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = SW'(i);
            end
        end
    end

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign sel = idx;
`else
    assign sel = idx + ptr;
`endif

    assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin sequencer owning the shared N-to-1 mux select, with a one-entry valid/ready output buffer.
// Build option: define MUX_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no pointer register).
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int  NREQ = 8,
    parameter int  W    = 32,
    localparam int SW   = calc_sw(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_src,
    input  logic              out_ready
);

    logic          full_q, full_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] src_q,  src_d;
    logic [SW-1:0] ptr;
    logic [SW-1:0] sel;
    logic          any;
    logic          can_load;
    logic          accept;

    logic [W-1:0] words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = req_data[g*W +: W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .sel (sel),
        .any (any)
    );

    assign can_load = !full_q || out_ready;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [SW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;

    // Pointer moves only on accept, to the slot just past the winner.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = sel + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        full_d    = full_q;
        data_d    = data_q;
        src_d     = src_q;
        req_ready = '0;
        if (any && can_load && !rst) begin
            req_ready = NREQ'(onehot(5'(sel)));
        end
        accept = |(req_valid & req_ready);
        if (accept) begin
            full_d = 1'b1;
            data_d = words[sel];
            src_d  = sel;
        end else if (full_q && out_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            src_q  <= src_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed steps then random traffic against a behavioural model.
module tb_mux_rr_arbiter;

    localparam int NREQ = 8;
    localparam int W    = 32;
    localparam int SW   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_src;
    logic              out_ready;

    int n_total  = 0;
    int n_passed = 0;

    // Reference model state
    int          m_full = 0;
    logic [31:0] m_data = '0;
    int          m_src  = 0;
    int          m_ptr  = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Search order starts at the pointer and wraps; fixed build always starts at 0.
    task automatic model_pick(output logic [NREQ-1:0] rdy, output int gidx);
        int start;
        rdy  = '0;
        gidx = -1;
`ifdef MUX_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        if (!rst && (m_full == 0 || out_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (start + k) % NREQ;
                if (gidx < 0 && req_valid[idx]) gidx = idx;
            end
            if (gidx >= 0) rdy[gidx] = 1'b1;
        end
    endtask

    task automatic do_cycle();
        logic [NREQ-1:0] exp_rdy;
        int              gidx;
        #1;
        model_pick(exp_rdy, gidx);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_data = '0; m_src = 0; m_ptr = 0;
        end else if (gidx >= 0) begin
            m_full = 1;
            m_data = req_data[gidx*W +: W];
            m_src  = gidx;
            m_ptr  = (gidx + 1) % NREQ;
        end else if (m_full != 0 && out_ready) begin
            m_full = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("out_data",  out_data,       m_data);
        chk("out_src",   32'(out_src),   32'(m_src));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 32'h100 + 32'(i);

        // Reset held two cycles with every requester valid
        repeat (2) do_cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);

        // Round-robin sweep, all valid, downstream always ready
        rst = 1'b0;
        do_cycle();
        chk("first_src", 32'(out_src), 32'd0);
        repeat (8) do_cycle();

        // Move pointer to 6, then only 1 and 5 request
        req_valid = 8'b0010_0000;
        do_cycle();
        req_valid = 8'b0010_0010;
        do_cycle();
`ifndef MUX_ARB_FIXED_PRIO_EN
        chk("wrap_first", 32'(out_src), 32'd1);
`endif
        req_valid = 8'b0010_0000;
        do_cycle();
        chk("skip_second", 32'(out_src), 32'd5);

        // Backpressure for five cycles, then release
        req_valid = '1;
        out_ready = 1'b0;
        repeat (5) do_cycle();
        chk("bp_ready_zero", 32'(req_ready), 32'd0);
        out_ready = 1'b1;
        do_cycle();

        // Reset while buffer holds 0xDEADBEEF
        req_valid = 8'b0000_1000;
        req_data[3*W +: W] = 32'hDEAD_BEEF;
        do_cycle();
        out_ready = 1'b0;
        req_valid = '0;
        do_cycle();
        chk("hold_deadbeef", out_data, 32'hDEAD_BEEF);
        rst = 1'b1;
        do_cycle();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_data",  out_data,       32'd0);
        rst = 1'b0;

`ifdef MUX_ARB_FIXED_PRIO_EN
        req_valid = 8'b0001_0100;
        out_ready = 1'b1;
        repeat (4) begin
            do_cycle();
            chk("fixed_src", 32'(out_src), 32'd2);
        end
`endif

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = NREQ'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = $urandom();
            do_cycle();
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
